rot_tlul_host: RTL and testbench
================================

// Module: rot_tlul_host
// PURPOSE
// - TL-UL initiator (host) that drives the RoT TL-UL responder port from a simple command/response interface.
// - Issues Get, PutFullData and PutPartialData on the A channel, and allocates source IDs up to MaxOutstanding.
// - Retires D-channel responses by source and returns them to the requester.
// - Sits between an SoC-side CSR sequencer or debug agent and the RoT CSR window; 32-bit data, 4-byte beats only.
// PARAMETERS
// - MaxOutstanding  4   concurrent transactions in flight (1..8); source IDs 0..MaxOutstanding-1
// - SrcW            8   width of a_bits_source / d_bits_source
// - TimeoutCycles   1024  idle-D cycles before timeout; used only with ROT_TLUL_HOST_TIMEOUT_EN
// PORTS
// - clk_i            in   1   clock
// - rst_ni           in   1   reset, asynchronous, active-low
// - cmd_valid_i      in   1   command request
// - cmd_ready_o      out  1   command accepted when valid&ready
// - cmd_we_i         in   1   1=write, 0=read
// - cmd_addr_i       in   32  byte address; bits[1:0] ignored (forced 0)
// - cmd_wdata_i      in   32  write data
// - cmd_be_i         in   4   write byte enables
// - rsp_valid_o      out  1   response available (combinational from d_valid)
// - rsp_ready_i      in   1   response consumed
// - rsp_rdata_o      out  32  read data (d_bits_data)
// - rsp_err_o        out  1   d_bits_denied OR unexpected source
// - rsp_source_o     out  SrcW  source ID of the retiring response
// - a_valid/a_ready  out/in 1  TL-UL A handshake
// - a_bits_opcode    out  3   0=PutFull, 1=PutPartial, 4=Get
// - a_bits_param     out  3   always 0
// - a_bits_size      out  2   always 2
// - a_bits_source    out  SrcW  allocated ID
// - a_bits_address   out  32  {cmd_addr[31:2],2'b00}
// - a_bits_mask      out  4   Get: 4'hF; Put: cmd_be
// - a_bits_data      out  32  cmd_wdata (0 for Get)
// - d_valid/d_ready  in/out 1  TL-UL D handshake; d_ready = rsp_ready_i
// - d_bits_opcode,d_bits_source,d_bits_data,d_bits_denied  in  3/SrcW/32/1  D fields
// - busy_o           out  1   any transaction in flight or A pending
// - err_unexp_o      out  1   sticky: D beat with source not in flight; cleared only by reset
// BEHAVIOUR
// - Reset: a_valid=0, all A fields 0, in-flight bitmap=0, count=0, busy_o=0, err_unexp_o=0, err_timeout_o=0.
// - A stage FSM:
//   - IDLE->HOLD on command accept; HOLD->IDLE on a_valid&a_ready.
//   - A fields are registered and stable while in HOLD.
// - cmd_ready_o = (state==IDLE) & (count<MaxOutstanding).
// - Latency: command accepted in cycle N gives a_valid in cycle N+1.
// - Source allocation:
//   - At command accept, the lowest-index clear bitmap bit is allocated and set.
//   - The source stays reserved from accept until its D beat retires.
// - Opcode selection: read -> Get. Write with be==4'hF -> PutFullData; any other be, including 4'h0, -> PutPartialData.
// - D retire on d_valid&d_ready:
//   - If bitmap[d_source] is set, clear it and decrement count.
//   - Otherwise set err_unexp_o and force rsp_err_o=1 for that beat; bitmap is unchanged.
// - Same-cycle allocate and retire: bitmap_next = (bitmap & ~retire) | alloc; count is unchanged.
// - The allocator never picks the retiring ID that cycle; it uses the pre-retire bitmap.
// - Full: at count==MaxOutstanding, cmd_ready_o=0; it rises the cycle after a retire.
// - Responses may return out of order; the consumer matches them by rsp_source_o.
// - busy_o = (state==HOLD) | (count!=0).
// - Reset mid-operation discards all state. Late D beats after reset are flagged unexpected.
// CONFIGURATION
// - ROT_TLUL_HOST_TIMEOUT_EN defined:
//   - Adds output err_timeout_o (1 bit, sticky) and a 16-bit watchdog.
//   - Watchdog counts while count!=0 and no D beat retires; it resets to 0 on any retire or when count==0.
//   - When it reaches TimeoutCycles: set err_timeout_o, clear bitmap and count, return FSM to IDLE (drop any held A).
//   - Late D beats after that are unexpected.
// - Not defined: no watchdog, no err_timeout_o port, and transactions wait forever.
// TESTING
// - Read 0x1000_0006, a_ready=1, D data 0xDEADBEEF src 0
//   -> A: op=4, addr=0x1000_0004, mask=F, src=0; rsp_rdata=0xDEADBEEF, err=0.
// - Writes with be=F then be=3 -> opcodes 0 then 1, masks F then 3, sources 0 and 1.
// - Four commands with d_valid held 0 -> sources 0..3 issued, then cmd_ready=0.
//   - Retire src 2 -> cmd_ready=1 next cycle; the next command gets src 2.
// - Same cycle: command accept and retire of src 0 with bitmap=4'b0011 -> new src=2, bitmap=4'b0110, count stays 2.
// - D beat src 5 while none in flight -> rsp_err=1, err_unexp_o=1 (stays 1); bitmap unchanged.
// - With TIMEOUT_EN and TimeoutCycles=16: one read, no D for 16 cycles -> err_timeout_o=1, busy_o=0, cmd_ready=1.

Source files
------------

// File: rtl/rot_tlul_host.sv
// rtl/rot_tlul_host.sv - TL-UL host driving RoT A/D channels from a command/response port
// Optional D-channel watchdog and err_timeout_o: define ROT_TLUL_HOST_TIMEOUT_EN.
module rot_tlul_host #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned SrcW           = 8,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [31:0]     cmd_addr_i,
    input  logic [31:0]     cmd_wdata_i,
    input  logic [3:0]      cmd_be_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_rdata_o,
    output logic            rsp_err_o,
    output logic [SrcW-1:0] rsp_source_o,
    output logic            a_valid_o,
    input  logic            a_ready_i,
    output logic [2:0]      a_bits_opcode_o,
    output logic [2:0]      a_bits_param_o,
    output logic [1:0]      a_bits_size_o,
    output logic [SrcW-1:0] a_bits_source_o,
    output logic [31:0]     a_bits_address_o,
    output logic [3:0]      a_bits_mask_o,
    output logic [31:0]     a_bits_data_o,
    input  logic            d_valid_i,
    output logic            d_ready_o,
    input  logic [2:0]      d_bits_opcode_i,
    input  logic [SrcW-1:0] d_bits_source_i,
    input  logic [31:0]     d_bits_data_i,
    input  logic            d_bits_denied_i,
`ifdef ROT_TLUL_HOST_TIMEOUT_EN
    output logic            err_timeout_o,
`endif
    output logic            busy_o,
    output logic            err_unexp_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {StIdle = 1'b0, StHold = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic [MaxOutstanding-1:0] bitmap_q, bitmap_d;
    logic [MaxOutstanding-1:0] free_onehot, match_vec, alloc, retire;
    logic [CntW-1:0]           count_q, count_d;
    logic [SrcW-1:0]           free_idx;
    logic [2:0]                a_opcode_q, a_opcode_d;
    logic [SrcW-1:0]           a_source_q, a_source_d;
    logic [31:0]               a_address_q, a_address_d;
    logic [31:0]               a_data_q, a_data_d;
    logic [3:0]                a_mask_q, a_mask_d;
    logic                      err_unexp_q, err_unexp_d;
    logic                      cmd_fire, d_fire, d_hit, timeout_hit;
    logic                      unused_inputs;

    assign unused_inputs = ^{d_bits_opcode_i, cmd_addr_i[1:0]};

    // Descending scan so the lowest clear bit wins; allocation sees the pre-retire bitmap.
    always_comb begin
        free_onehot = '0;
        free_idx    = '0;
        for (int i = MaxOutstanding - 1; i >= 0; i--) begin
            if (!bitmap_q[i]) begin
                free_onehot    = '0;
                free_onehot[i] = 1'b1;
                free_idx       = SrcW'(i);
            end
        end
    end

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < MaxOutstanding; i++) begin
            match_vec[i] = bitmap_q[i] & (d_bits_source_i == SrcW'(i));
        end
    end

    assign d_hit       = |match_vec;
    assign d_fire      = d_valid_i & rsp_ready_i;
    assign retire      = d_fire ? match_vec : '0;
    assign cmd_ready_o = (state_q == StIdle) && (count_q < CntW'(MaxOutstanding)) && !timeout_hit;
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;
    assign alloc       = cmd_fire ? free_onehot : '0;

    always_comb begin
        state_d     = state_q;
        a_opcode_d  = a_opcode_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_data_d    = a_data_q;
        a_mask_d    = a_mask_q;
        bitmap_d    = (bitmap_q & ~retire) | alloc;
        count_d     = count_q;
        err_unexp_d = err_unexp_q | (d_fire & ~d_hit);
        if (cmd_fire && !(|retire)) begin
            count_d = count_q + CntW'(1);
        end else if (!cmd_fire && (|retire)) begin
            count_d = count_q - CntW'(1);
        end
        case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    state_d     = StHold;
                    a_source_d  = free_idx;
                    a_address_d = {cmd_addr_i[31:2], 2'b00};
                    a_opcode_d  = !cmd_we_i ? 3'd4 : ((cmd_be_i == 4'hF) ? 3'd0 : 3'd1);
                    a_mask_d    = cmd_we_i ? cmd_be_i : 4'hF;
                    a_data_d    = cmd_we_i ? cmd_wdata_i : 32'd0;
                end
            end
            StHold: begin
                if (a_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (timeout_hit) begin
            state_d  = StIdle;
            bitmap_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bitmap_q    <= '0;
            count_q     <= '0;
            a_opcode_q  <= '0;
            a_source_q  <= '0;
            a_address_q <= '0;
            a_data_q    <= '0;
            a_mask_q    <= '0;
            err_unexp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitmap_q    <= bitmap_d;
            count_q     <= count_d;
            a_opcode_q  <= a_opcode_d;
            a_source_q  <= a_source_d;
            a_address_q <= a_address_d;
            a_data_q    <= a_data_d;
            a_mask_q    <= a_mask_d;
            err_unexp_q <= err_unexp_d;
        end
    end

`ifdef ROT_TLUL_HOST_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        err_timeout_q;

    assign timeout_hit = (count_q != '0) && !(|retire) && (wdog_q == 16'(TimeoutCycles - 1));
    assign wdog_d      = ((count_q == '0) || (|retire) || timeout_hit) ? 16'd0 : wdog_q + 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            err_timeout_q <= err_timeout_q | timeout_hit;
        end
    end

    assign err_timeout_o = err_timeout_q;
`else
    localparam int unsigned unused_timeout_cycles = TimeoutCycles;
    assign timeout_hit = 1'b0;
`endif

    assign a_valid_o        = (state_q == StHold);
    assign a_bits_opcode_o  = a_opcode_q;
    assign a_bits_param_o   = 3'd0;
    assign a_bits_size_o    = 2'd2;
    assign a_bits_source_o  = a_source_q;
    assign a_bits_address_o = a_address_q;
    assign a_bits_mask_o    = a_mask_q;
    assign a_bits_data_o    = a_data_q;
    assign d_ready_o        = rsp_ready_i;
    assign rsp_valid_o      = d_valid_i;
    assign rsp_rdata_o      = d_bits_data_i;
    assign rsp_source_o     = d_bits_source_i;
    assign rsp_err_o        = d_bits_denied_i | ~d_hit;
    assign busy_o           = (state_q == StHold) || (count_q != '0);
    assign err_unexp_o      = err_unexp_q;
endmodule

// File: tb/tb_rot_tlul_host.sv
// tb/tb_rot_tlul_host.sv - scoreboard bench for rot_tlul_host; ROT_TLUL_HOST_TIMEOUT_EN adds the watchdog scenario
module tb_rot_tlul_host;
    localparam int unsigned MaxOut = 4;
    localparam int unsigned SrcW   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [31:0]     cmd_addr, cmd_wdata;
    logic [3:0]      cmd_be;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [31:0]     rsp_rdata;
    logic [SrcW-1:0] rsp_source;
    logic            a_valid, a_ready;
    logic [2:0]      a_opcode, a_param;
    logic [1:0]      a_size;
    logic [SrcW-1:0] a_source;
    logic [31:0]     a_address, a_data;
    logic [3:0]      a_mask;
    logic            d_valid, d_ready, d_denied;
    logic [2:0]      d_opcode;
    logic [SrcW-1:0] d_source;
    logic [31:0]     d_data;
    logic            busy, err_unexp;
`ifdef ROT_TLUL_HOST_TIMEOUT_EN
    logic            err_timeout;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]      op;
        logic [31:0]     addr;
        logic [3:0]      mask;
        logic [31:0]     data;
        logic [SrcW-1:0] src;
    } a_beat_t;

    a_beat_t          exp_a[$];
    a_beat_t          mon_exp, mon_got;
    logic [MaxOut-1:0] mdl_bm;

    always #5 clk = ~clk;

    rot_tlul_host #(.MaxOutstanding(MaxOut), .SrcW(SrcW), .TimeoutCycles(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_source_o(rsp_source),
        .a_valid_o(a_valid), .a_ready_i(a_ready), .a_bits_opcode_o(a_opcode),
        .a_bits_param_o(a_param), .a_bits_size_o(a_size), .a_bits_source_o(a_source),
        .a_bits_address_o(a_address), .a_bits_mask_o(a_mask), .a_bits_data_o(a_data),
        .d_valid_i(d_valid), .d_ready_o(d_ready), .d_bits_opcode_i(d_opcode),
        .d_bits_source_i(d_source), .d_bits_data_i(d_data), .d_bits_denied_i(d_denied),
`ifdef ROT_TLUL_HOST_TIMEOUT_EN
        .err_timeout_o(err_timeout),
`endif
        .busy_o(busy), .err_unexp_o(err_unexp)
    );

    // A-channel monitor: each accepted beat is matched against the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            mon_got = '{op: a_opcode, addr: a_address, mask: a_mask, data: a_data, src: a_source};
            checks++;
            if (exp_a.size() == 0) begin
                failures++;
                $display("FAIL a_beat_unexpected got=%h required=none", mon_got);
            end else begin
                mon_exp = exp_a.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL a_beat got op=%0d addr=%h mask=%h data=%h src=%0d required op=%0d addr=%h mask=%h data=%h src=%0d",
                             mon_got.op, mon_got.addr, mon_got.mask, mon_got.data, mon_got.src,
                             mon_exp.op, mon_exp.addr, mon_exp.mask, mon_exp.data, mon_exp.src);
                end
            end
            checks++;
            if (a_param !== 3'd0 || a_size !== 2'd2) begin
                failures++;
                $display("FAIL a_param_size got=%0d/%0d required=0/2", a_param, a_size);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int              n;
        logic            found;
        logic [SrcW-1:0] src;
        a_beat_t         e;
        n = 0;
        while (!cmd_ready && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_wait got=%b required=1", cmd_ready);
        end
        found = 1'b0;
        src   = '0;
        for (int i = 0; i < MaxOut; i++) begin
            if (!mdl_bm[i] && !found) begin
                src   = SrcW'(i);
                found = 1'b1;
            end
        end
        e.op   = !we ? 3'd4 : ((be == 4'hF) ? 3'd0 : 3'd1);
        e.addr = {addr[31:2], 2'b00};
        e.mask = we ? be : 4'hF;
        e.data = we ? wdata : 32'd0;
        e.src  = src;
        exp_a.push_back(e);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        tick();
        cmd_valid = 1'b0;
        mdl_bm[src[1:0]] = 1'b1;
        checks++;
        if (a_valid !== 1'b1) begin
            failures++;
            $display("FAIL a_valid_latency got=%b required=1", a_valid);
        end
    endtask

    task automatic d_beat(input logic [SrcW-1:0] src, input logic [31:0] data, input logic denied);
        logic in_flight;
        in_flight = (src < MaxOut) ? mdl_bm[src[1:0]] : 1'b0;
        d_valid   = 1'b1;
        d_source  = src;
        d_data    = data;
        d_denied  = denied;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== data || rsp_source !== src || d_ready !== 1'b1) begin
            failures++;
            $display("FAIL rsp_fields got v=%b data=%h src=%0d dr=%b required v=1 data=%h src=%0d dr=1",
                     rsp_valid, rsp_rdata, rsp_source, d_ready, data, src);
        end
        checks++;
        if (rsp_err !== (denied | !in_flight)) begin
            failures++;
            $display("FAIL rsp_err src=%0d got=%b required=%b", src, rsp_err, denied | !in_flight);
        end
        tick();
        d_valid = 1'b0;
        if (in_flight) mdl_bm[src[1:0]] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl_bm = '0;
        exp_a.delete();
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (a_valid !== 1'b0 || busy !== 1'b0 || err_unexp !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got a_valid=%b busy=%b err_unexp=%b required 0/0/0", a_valid, busy, err_unexp);
        end
        checks++;
        if (a_opcode !== 3'd0 || a_address !== 32'd0 || a_source !== '0 || a_mask !== 4'd0 || a_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_a_fields got op=%0d addr=%h src=%0d mask=%h data=%h required all 0",
                     a_opcode, a_address, a_source, a_mask, a_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%b required=1", cmd_ready);
        end
    endtask

    task automatic test_read();
        issue(1'b0, 32'h1000_0006, 32'h0, 4'h0);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL read_busy got=%b required=1", busy);
        end
        d_beat(8'd0, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL read_idle got=%b required=0", busy);
        end
    endtask

    task automatic test_writes();
        issue(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF);
        issue(1'b1, 32'h0000_0027, 32'h1234_5678, 4'h3);
        issue(1'b1, 32'h0000_0028, 32'hCAFE_F00D, 4'h0);
        tick();
        d_beat(8'd1, 32'h0, 1'b0);
        d_beat(8'd2, 32'h0, 1'b1);
        d_beat(8'd0, 32'h0, 1'b0);
    endtask

    task automatic test_hold();
        a_ready = 1'b0;
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        repeat (3) tick();
        checks++;
        if (a_valid !== 1'b1 || cmd_ready !== 1'b0 || a_address !== 32'h0000_0100) begin
            failures++;
            $display("FAIL hold_a got a_valid=%b cmd_ready=%b addr=%h required 1/0/00000100", a_valid, cmd_ready, a_address);
        end
        a_ready = 1'b1;
        tick();
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_release got=%b required=0", a_valid);
        end
        d_beat(8'd0, 32'h0000_0055, 1'b0);
    endtask

    task automatic test_full_and_same_cycle();
        for (int k = 0; k < 4; k++) issue(1'b0, 32'h0000_0200 + 32'(4 * k), 32'h0, 4'h0);
        tick();
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL full_ready got cmd_ready=%b busy=%b required 0/1", cmd_ready, busy);
        end
        d_beat(8'd2, 32'h2222_2222, 1'b0);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_reopen got=%b required=1", cmd_ready);
        end
        issue(1'b0, 32'h0000_0300, 32'h0, 4'h0);
        tick();
        d_beat(8'd2, 32'h0, 1'b0);
        d_beat(8'd3, 32'h0, 1'b0);
        // Bitmap is now 4'b0011: accept a command while source 0 retires.
        d_valid  = 1'b1;
        d_source = 8'd0;
        d_data   = 32'h0000_0AAA;
        d_denied = 1'b0;
        #1;
        checks++;
        if (rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_err got=%b required=0", rsp_err);
        end
        issue(1'b1, 32'h0000_0400, 32'h0BAD_CAFE, 4'hF);
        d_valid   = 1'b0;
        mdl_bm[0] = 1'b0;
        tick();
        issue(1'b0, 32'h0000_0404, 32'h0, 4'h0);
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_count got cmd_ready=%b required=1", cmd_ready);
        end
        d_beat(8'd1, 32'h0, 1'b0);
        d_beat(8'd2, 32'h0, 1'b0);
        d_beat(8'd0, 32'h0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_drain got busy=%b required=0", busy);
        end
    endtask

    task automatic test_unexpected();
        d_beat(8'd5, 32'h0000_0005, 1'b0);
        repeat (3) tick();
        checks++;
        if (err_unexp !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL unexp_sticky got err_unexp=%b busy=%b required 1/0", err_unexp, busy);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h0000_0500, 32'h0, 4'h0);
        tick();
        do_reset();
        checks++;
        if (busy !== 1'b0 || err_unexp !== 1'b0 || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset got busy=%b err_unexp=%b a_valid=%b required 0/0/0", busy, err_unexp, a_valid);
        end
        rst_n = 1'b1;
        tick();
        d_beat(8'd0, 32'h0000_0666, 1'b0);
        checks++;
        if (err_unexp !== 1'b1) begin
            failures++;
            $display("FAIL midreset_late got=%b required=1", err_unexp);
        end
    endtask

`ifdef ROT_TLUL_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        rst_n = 1'b1;
        tick();
        issue(1'b0, 32'h0000_0600, 32'h0, 4'h0);
        n = 0;
        while (err_timeout !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (err_timeout !== 1'b1 || n != 16) begin
            failures++;
            $display("FAIL timeout_fire got err=%b cycles=%0d required err=1 cycles=16", err_timeout, n);
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_state got busy=%b cmd_ready=%b required 0/1", busy, cmd_ready);
        end
        mdl_bm = '0;
        d_beat(8'd0, 32'h0, 1'b0);
        checks++;
        if (err_unexp !== 1'b1 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_late got unexp=%b timeout=%b required 1/1", err_unexp, err_timeout);
        end
    endtask
`endif

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        rsp_ready = 1'b1; a_ready = 1'b1;
        d_valid = 1'b0; d_opcode = 3'd1; d_source = '0; d_data = '0; d_denied = 1'b0;
        rst_n = 1'b0;
        mdl_bm = '0;
        test_reset();
        test_read();
        test_writes();
        test_hold();
        test_full_and_same_cycle();
        test_unexpected();
        test_reset_mid();
`ifdef ROT_TLUL_HOST_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        checks++;
        if (exp_a.size() != 0) begin
            failures++;
            $display("FAIL a_beats_outstanding got=%0d required=0", exp_a.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
